// File: rtl/tart_fake_signal.sv
// Synthetic antenna source: LFSR sample word every RATIO clocks with +/-SHAKE deterministic jitter.
// All outputs registered; enable low holds the word and restarts the start-up offset.
module tart_fake_signal #(
  parameter int          WIDTH = 24,
  parameter int          RATIO = 12,
  parameter int          SHAKE = 2,
  parameter logic [31:0] SEED  = 32'h00000001,
  parameter int          DELAY = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic             locked,
  output logic             strobe,
  output logic [WIDTH-1:0] signal
);

  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam int          CW        = (RATIO + SHAKE > 1) ? $clog2(RATIO + SHAKE) : 1;
  localparam logic [CW-1:0] CNT_START = CW'(RATIO + SHAKE - 1);
  localparam logic [31:0] JIT_MOD   = 32'(2 * SHAKE + 1);
  // Reload base folds the -SHAKE offset and the -1 of a down-counter into one constant.
  localparam logic [31:0] JIT_BASE  = 32'(RATIO - SHAKE - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tart_fake_signal: WIDTH must be within 1..32");
  end
  if (SHAKE < 0 || 2 * SHAKE >= RATIO) begin : g_bad_shake
    $error("tart_fake_signal: need 0 <= 2*SHAKE < RATIO");
  end
  if (SEED == 32'd0) begin : g_bad_seed
    $error("tart_fake_signal: SEED must be nonzero");
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("tart_fake_signal: DELAY must be non-negative");
  end

  logic [31:0]   lfsr;
  logic [31:0]   lfsr_adv;
  logic [31:0]   jit_mod;
  logic [CW-1:0] cnt;

  always_comb begin
    lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    // Jitter is drawn from the post-advance state so each period depends on the word just emitted.
    jit_mod  = {24'd0, lfsr_adv[31:24]} % JIT_MOD;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr   <= SEED;
      cnt    <= CNT_START;
      locked <= 1'b0;
      strobe <= 1'b0;
      signal <= '0;
    end else if (!enable) begin
      cnt    <= CNT_START;
      locked <= 1'b0;
      strobe <= 1'b0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      strobe <= 1'b0;
    end else begin
      signal <= lfsr[WIDTH-1:0];
      lfsr   <= lfsr_adv;
      strobe <= 1'b1;
      locked <= 1'b1;
      cnt    <= CW'(JIT_BASE + jit_mod);
    end
  end

endmodule

// File: tb/tb_tart_fake_signal.sv
// Bench for tart_fake_signal: directed start-up/enable-gap cases plus a randomized enable run
// checked against an event-level model (LFSR word per emit, per-sample gap from the jitter rule).
module tb_tart_fake_signal;

  localparam int          WIDTH = 24;
  localparam int          RATIO = 12;
  localparam int          SHAKE = 2;
  localparam logic [31:0] SEED  = 32'h00000001;
  localparam logic [31:0] TAPS  = 32'h80200003;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             locked_a, strobe_a, locked_b, strobe_b;
  logic [WIDTH-1:0] signal_a, signal_b;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_lfsr;

  always #5 clock = ~clock;

  tart_fake_signal #(.WIDTH(WIDTH), .RATIO(RATIO), .SHAKE(SHAKE), .SEED(SEED), .DELAY(3)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .locked(locked_a), .strobe(strobe_a), .signal(signal_a)
  );

  tart_fake_signal #(.WIDTH(WIDTH), .RATIO(RATIO), .SHAKE(0), .SEED(SEED), .DELAY(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .locked(locked_b), .strobe(strobe_b), .signal(signal_b)
  );

  function automatic logic [31:0] adv(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  // Cycles from one emit to the next, given the LFSR value after the emit.
  function automatic int gap_after(input logic [31:0] l, input int shake);
    return RATIO + (int'(l[31:24]) % (2 * shake + 1)) - shake;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    enable  = 1'b1;
    reset_n = 1'b0;
    step;
    step;
    reset_n = 1'b1;
    model_lfsr = SEED;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      total++;
      if ({signal_a, strobe_a, locked_a} !== {{WIDTH{1'b0}}, 2'b00}) begin
        bad++;
        $display("FAIL reset_a[%0d]: signal=%h strobe=%b locked=%b, want 0/0/0", c, signal_a, strobe_a, locked_a);
      end
      total++;
      if ({signal_b, strobe_b, locked_b} !== {{WIDTH{1'b0}}, 2'b00}) begin
        bad++;
        $display("FAIL reset_b[%0d]: signal=%h strobe=%b locked=%b, want 0/0/0", c, signal_b, strobe_b, locked_b);
      end
    end
    reset_n = 1'b1;
    model_lfsr = SEED;
  endtask

  task automatic test_first_samples;
    int               exp_gap [3] = '{14, 13, 12};
    logic [WIDTH-1:0] exp_sig [3] = '{24'h000001, 24'h200003, 24'h300002};
    int               n;
    bit               early_lock;
    early_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        step;
        n++;
        if (k == 0 && !strobe_a && locked_a) early_lock = 1'b1;
      end while (!strobe_a && n < 40);
      total++;
      if (!strobe_a || n != exp_gap[k] || n != (k == 0 ? RATIO + SHAKE : gap_after(model_lfsr, SHAKE))) begin
        bad++;
        $display("FAIL first_gap[%0d]: got %0d cycles (strobe=%b), want %0d", k, n, strobe_a, exp_gap[k]);
      end
      total++;
      if (signal_a !== exp_sig[k] || signal_a !== model_lfsr[WIDTH-1:0]) begin
        bad++;
        $display("FAIL first_signal[%0d]: got %h want %h", k, signal_a, exp_sig[k]);
      end
      total++;
      if (locked_a !== 1'b1) begin
        bad++;
        $display("FAIL first_locked[%0d]: got %b want 1", k, locked_a);
      end
      model_lfsr = adv(model_lfsr);
    end
    total++;
    if (early_lock) begin
      bad++;
      $display("FAIL early_lock: locked was 1 before first strobe, want 0");
    end
    step;
    total++;
    if (strobe_a !== 1'b0 || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL strobe_width: strobe=%b locked=%b after emit, want 0/1", strobe_a, locked_a);
    end
  endtask

  task automatic test_enable_gap;
    int n;
    do_reset;
    n = 0;
    do begin step; n++; end while (!strobe_a && n < 40);
    model_lfsr = adv(model_lfsr);
    repeat (5) step;
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      total++;
      if (locked_a !== 1'b0 || strobe_a !== 1'b0 || signal_a !== 24'h000001) begin
        bad++;
        $display("FAIL gap_hold[%0d]: locked=%b strobe=%b signal=%h, want 0/0/000001", c, locked_a, strobe_a, signal_a);
      end
    end
    enable = 1'b1;
    n = 0;
    do begin step; n++; end while (!strobe_a && n < 40);
    total++;
    if (!strobe_a || n != RATIO + SHAKE) begin
      bad++;
      $display("FAIL reenable_gap: got %0d cycles (strobe=%b), want %0d", n, strobe_a, RATIO + SHAKE);
    end
    total++;
    if (signal_a !== 24'h200003 || signal_a !== model_lfsr[WIDTH-1:0] || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL reenable_signal: got %h locked=%b, want 200003 locked=1", signal_a, locked_a);
    end
  endtask

  task automatic test_random_enable;
    int               since, gap;
    bit               seen, en_now, exp_strobe;
    logic [WIDTH-1:0] held;
    do_reset;
    since = 0;
    gap   = RATIO + SHAKE;
    seen  = 1'b0;
    held  = '0;
    for (int c = 0; c < 1500; c++) begin
      if (enable) begin
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
      en_now = enable;
      step;
      exp_strobe = 1'b0;
      if (!en_now) begin
        since = 0;
        gap   = RATIO + SHAKE;
        seen  = 1'b0;
      end else begin
        since++;
        if (since == gap) begin
          exp_strobe = 1'b1;
          held       = model_lfsr[WIDTH-1:0];
          model_lfsr = adv(model_lfsr);
          gap        = gap_after(model_lfsr, SHAKE);
          since      = 0;
          seen       = 1'b1;
        end
      end
      total++;
      if (strobe_a !== exp_strobe || signal_a !== held || locked_a !== seen) begin
        bad++;
        $display("FAIL random[%0d]: strobe=%b signal=%h locked=%b, want %b/%h/%b",
                 c, strobe_a, signal_a, locked_a, exp_strobe, held, seen);
      end
    end
  endtask

  task automatic test_shake0;
    int          n;
    logic [31:0] m;
    do_reset;
    m = SEED;
    for (int s = 0; s < 100; s++) begin
      n = 0;
      do begin step; n++; end while (!strobe_b && n < 30);
      total++;
      if (!strobe_b || n != RATIO) begin
        bad++;
        $display("FAIL shake0_gap[%0d]: got %0d cycles (strobe=%b), want %0d", s, n, strobe_b, RATIO);
      end
      total++;
      if (signal_b !== m[WIDTH-1:0]) begin
        bad++;
        $display("FAIL shake0_signal[%0d]: got %h want %h", s, signal_b, m[WIDTH-1:0]);
      end
      m = adv(m);
    end
  endtask

  initial begin
    test_reset;
    test_first_samples;
    test_enable_gap;
    test_random_enable;
    test_shake0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
